// File: rtl/mu_fifo_sync_pkg.sv
// Shared constants and a width helper for the sync FIFO controller and its RAM.
package mu_fifo_sync_pkg;

  // Default geometry: 8-bit thermal pixels, 4K-entry buffer.
  localparam int MU_DW_DEF = 8;
  localparam int MU_AW_DEF = 12;

  // Pointers and the level count carry one extra bit over the RAM address so
  // that a full RAM (2^AW entries) is distinguishable from an empty one.
  function automatic int mu_level_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/mu_fifo_sync_ram.sv
// Simple dual-port 1R1W RAM with a registered read port (one cycle latency).
// The read data register is intentionally not reset.
module mu_fifo_sync_ram
  import mu_fifo_sync_pkg::*;
#(
  parameter int DW = MU_DW_DEF,
  parameter int AW = MU_AW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wr,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] rd_q;

  // Write port: store on we.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wr;
    end
  end

  // Read port: capture addressed word on re; holds otherwise.
  always_ff @(posedge clk) begin
    if (re) begin
      rd_q <= mem_q[raddr];
    end
  end

  assign rd = rd_q;

endmodule

// File: rtl/mu_fifo_sync.sv
// Valid/ready streaming FIFO controller wrapped around a registered-read RAM.
// The RAM read register doubles as the output stage, so total capacity is
// 2^AW + 1 entries and read latency is hidden from the consumer.
module mu_fifo_sync
  import mu_fifo_sync_pkg::*;
#(
  parameter int DW = MU_DW_DEF,
  parameter int AW = MU_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int LW = mu_level_w(AW);
  localparam logic [LW-1:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [LW-1:0] ONE   = LW'(1);

  logic [LW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] rptr_q, rptr_d;
  logic          m_valid_q, m_valid_d;
  logic [LW-1:0] ram_cnt;
  logic          push;
  logic          re;

  // Entries sitting in the RAM, not yet moved into the output register.
  // Modular subtraction keeps this correct across pointer wrap.
  assign ram_cnt = wptr_q - rptr_q;

  // Ready depends only on registered state plus rst/flush, never on s_valid.
  assign s_ready = !rst && !flush && (ram_cnt != DEPTH);
  assign push    = s_valid && s_ready;

  // Refill the output register when it is empty or being consumed. Because
  // ram_cnt != 0 is required, the read never hits the slot written this cycle.
  assign re = (ram_cnt != '0) && (!m_valid_q || m_ready) && !flush && !rst;

  // Next-state for pointers and output valid; flush wins over push and pop.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    m_valid_d = m_valid_q;
    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      m_valid_d = 1'b0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + ONE;
      end
      if (re) begin
        rptr_d    = rptr_q + ONE;
        m_valid_d = 1'b1;
      end else if (m_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards contents exactly like flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      m_valid_q <= m_valid_d;
    end
  end

  mu_fifo_sync_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q[AW-1:0]),
    .wr    (s_data),
    .re    (re),
    .raddr (rptr_q[AW-1:0]),
    .rd    (m_data)
  );

  assign m_valid = m_valid_q;
  assign level   = ram_cnt + LW'(m_valid_q);
  assign full    = !rst && !s_ready;
  assign empty   = (level == '0);

endmodule

// File: tb/tb_mu_fifo_sync.sv
// Self-checking bench for mu_fifo_sync: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mu_fifo_sync;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW:0]   level;
  logic          full;
  logic          empty;

  mu_fifo_sync #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of words still in RAM, plus the output stage.
  logic [DW-1:0] mq[$];
  bit            mv = 1'b0;
  logic [DW-1:0] md = '0;
  bit            chk_en = 1'b0;

  function automatic bit exp_sready();
    return !rst && !flush && (mq.size() != DEPTH);
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit rd;
    if (rst || flush) begin
      mq.delete();
      mv = 1'b0;
    end else begin
      acc = s_valid && exp_sready();
      rd  = (mq.size() != 0) && (!mv || m_ready);
      if (rd) begin
        md = mq.pop_front();
        mv = 1'b1;
      end else if (m_ready) begin
        mv = 1'b0;
      end
      if (acc) mq.push_back(s_data);
    end
  end

  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_d = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_s_ready", s_ready, exp_sready());
      chk("m_m_valid", m_valid, mv);
      if (mv) chk("m_m_data", m_data, md);
      chk("m_level", level, mq.size() + int'(mv));
      chk("m_empty", empty, (mq.size() + int'(mv)) == 0);
      if (!rst) chk("m_full", full, !exp_sready());
      if (hold_q) chk("m_hold_stable", {m_valid, m_data}, {1'b1, hold_d});
      hold_q = m_valid && !m_ready && !rst && !flush;
      hold_d = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int got;
    int pops;
    int cyc;
    int pv;
    int pr;

    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);

    // Single push of 0xA5.
    s_data = 8'hA5; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; #1;
    chk("single_lvl_c1", level, 1);
    chk("single_mv_c1", m_valid, 0);
    tick();
    chk("single_mv_c2", m_valid, 1);
    chk("single_data_c2", m_data, 8'hA5);
    chk("single_lvl_c2", level, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; #1;
    chk("single_lvl_after", level, 0);
    chk("single_empty_after", empty, 1);

    // Fill with consumer stalled: capacity is DEPTH + 1.
    acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      s_data = DW'(i); s_valid = 1'b1; #1;
      if (s_ready) acc++;
      tick();
    end
    s_valid = 1'b0; #1;
    chk("fill_accepted", acc, DEPTH + 1);
    chk("fill_level", level, DEPTH + 1);
    chk("fill_full", full, 1);
    chk("fill_s_ready", s_ready, 0);
    m_ready = 1'b1; got = 0;
    for (int c = 0; c < DEPTH + 5; c++) begin
      #1;
      if (m_valid && m_ready) begin
        chk("drain_order", m_data, got);
        got++;
      end
      tick();
    end
    chk("drain_count", got, DEPTH + 1);
    chk("drain_empty", empty, 1);

    // Streaming at full rate: 2-cycle latency, no bubbles, level steady at 2.
    for (int k = 0; k < 20; k++) begin
      s_data = DW'(8'h40 + k); s_valid = 1'b1; m_ready = 1'b1; #1;
      if (k >= 2) begin
        chk("stream_valid", m_valid, 1);
        chk("stream_data", m_data, 8'h40 + k - 2);
        chk("stream_level", level, 2);
      end
      tick();
    end
    s_valid = 1'b0;
    repeat (4) tick();
    chk("stream_empty", empty, 1);
    m_ready = 1'b0;

    // Random valid/ready stalls, 10k words, wrapping many times.
    acc = 0; pops = 0; cyc = 0; pv = 2; pr = 2;
    while (acc < 10000 && cyc < 60000) begin
      if (cyc % 256 == 0) begin
        pv = int'($urandom_range(1, 4));
        pr = int'($urandom_range(1, 4));
      end
      s_valid = (int'($urandom_range(0, 3)) < pv);
      m_ready = (int'($urandom_range(0, 3)) < pr);
      s_data  = DW'($urandom);
      #1;
      if (s_valid && s_ready) acc++;
      if (m_valid && m_ready) pops++;
      tick();
      cyc++;
    end
    chk("rand_accepted", acc, 10000);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < DEPTH + 6; c++) begin
      #1;
      if (m_valid && m_ready) pops++;
      tick();
    end
    chk("rand_words_out", pops, 10000);
    chk("rand_empty", empty, 1);
    m_ready = 1'b0;

    // Flush with three stored entries and a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      s_data = DW'(8'h10 + i); s_valid = 1'b1;
      tick();
    end
    flush = 1'b1; s_data = 8'h77; #1;
    chk("flush_pre_level", level, 3);
    chk("flush_s_ready", s_ready, 0);
    tick();
    flush = 1'b0; s_valid = 1'b0; #1;
    chk("flush_level", level, 0);
    chk("flush_m_valid", m_valid, 0);
    chk("flush_empty", empty, 1);
    s_data = 8'h3C; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("flush_next_valid", m_valid, 1);
    chk("flush_next_data", m_data, 8'h3C);
    tick();
    chk("flush_next_empty", empty, 1);
    m_ready = 1'b0;

    // Reset pulse mid-stream with four entries held.
    for (int i = 0; i < 4; i++) begin
      s_data = DW'(8'h20 + i); s_valid = 1'b1;
      tick();
    end
    s_data = 8'h99; rst = 1'b1; #1;
    chk("rst_mid_pre_level", level, 4);
    chk("rst_mid_s_ready", s_ready, 0);
    tick();
    rst = 1'b0; s_valid = 1'b0; #1;
    chk("rst_mid_level", level, 0);
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_full", full, 0);
    chk("rst_mid_s_ready_after", s_ready, 1);
    s_data = 8'h5A; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("rst_mid_next_valid", m_valid, 1);
    chk("rst_mid_next_data", m_data, 8'h5A);
    tick();
    chk("rst_mid_next_empty", empty, 1);
    m_ready = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
